// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//
// Groups the requester handshake and the shared PET bus signals of the
// bus_arbiter so they travel as one bundle.
//
// Parameters
//   NUM_REQ  number of requester channels
//   ADDR_W   bus address width
//   DATA_W   bus data width
//
// Signals (direction as seen by the arbiter, i.e. the master modport)
//   req_valid_i  in   per-channel request pending
//   req_addr_i   in   packed addresses, channel n at [n*ADDR_W +: ADDR_W]
//   req_data_i   in   packed write data, channel n at [n*DATA_W +: DATA_W]
//   req_rw_ni    in   per-channel 1 = read, 0 = write
//   req_ready_o  out  one-hot, one-clock completion pulse
//   rd_data_o    out  captured read data
//   bus_addr_o   out  bus address, qualified by bus_addr_oe
//   bus_data_o   out  bus write data, qualified by bus_data_oe
//   bus_data_i   in   bus read data
//   bus_rw_no    out  bus rw strobe, qualified by bus_rw_noe
//
// Modports
//   master  the arbiter
//   slave   the requesters and the bus model on the other side
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_rw_ni;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]         rd_data_o;

  logic [ADDR_W-1:0]         bus_addr_o;
  logic                      bus_addr_oe;
  logic [DATA_W-1:0]         bus_data_o;
  logic                      bus_data_oe;
  logic [DATA_W-1:0]         bus_data_i;
  logic                      bus_rw_no;
  logic                      bus_rw_noe;

  modport master (
    input  req_valid_i,
    input  req_addr_i,
    input  req_data_i,
    input  req_rw_ni,
    output req_ready_o,
    output rd_data_o,
    output bus_addr_o,
    output bus_addr_oe,
    output bus_data_o,
    output bus_data_oe,
    input  bus_data_i,
    output bus_rw_no,
    output bus_rw_noe
  );

  modport slave (
    output req_valid_i,
    output req_addr_i,
    output req_data_i,
    output req_rw_ni,
    input  req_ready_o,
    input  rd_data_o,
    input  bus_addr_o,
    input  bus_addr_oe,
    input  bus_data_o,
    input  bus_data_oe,
    output bus_data_i,
    input  bus_rw_no,
    input  bus_rw_noe
  );

endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// System-bus sequencer that time-slices the shared PET bus between the 6502
// and up to NUM_REQ host-side requesters. Each frame is 2*PHASE_CYCLES
// system clocks: a CPU half where the 6502 owns the bus (cpu_clk_o high,
// cpu_be_o high) and a DMA half where one pending requester, chosen by
// round-robin, gets a single bus cycle.
//
// Parameters
//   NUM_REQ       number of requester channels (>= 1)
//   ADDR_W        bus address width
//   DATA_W        bus data width
//   PHASE_CYCLES  system clocks per half-frame (>= 4)
//
// Ports
//   clk_sys_i  in   system clock, all logic on the rising edge
//   reset_i    in   asynchronous, active-high reset
//   bus        --   bus_arbiter_if.master: requester handshake + PET bus
//   cpu_clk_o  out  CPU clock, clk_sys_i / (2*PHASE_CYCLES), 50% duty
//   cpu_be_o   out  CPU bus enable
//
// Every output is a register loaded from a decode of the current
// counter/phase/FSM state, so what appears on the pins during a clock is
// the decode of the state held during the previous clock. Counting cnt
// that way, bus enables are high for DMA cnt 1..PHASE_CYCLES-2 and the
// ready pulse shares the last enabled clock.
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 8,
  parameter int PHASE_CYCLES = 8
) (
  input  logic          clk_sys_i,
  input  logic          reset_i,
  bus_arbiter_if.master bus,
  output logic          cpu_clk_o,
  output logic          cpu_be_o
);

  localparam int CNT_W = $clog2(PHASE_CYCLES);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CAPT = CNT_W'(PHASE_CYCLES - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    TURN
  } state_t;

  typedef enum logic {
    PH_CPU,
    PH_DMA
  } phase_t;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [ADDR_W-1:0]   xfer_addr_q, xfer_addr_d;
  logic [DATA_W-1:0]   xfer_data_q, xfer_data_d;
  logic                xfer_rw_n_q, xfer_rw_n_d;

  logic                cpu_clk_d;
  logic                cpu_be_d;
  logic [NUM_REQ-1:0]  ready_d;
  logic [DATA_W-1:0]   rd_data_d;
  logic [ADDR_W-1:0]   bus_addr_d;
  logic                bus_addr_oe_d;
  logic [DATA_W-1:0]   bus_data_d;
  logic                bus_data_oe_d;
  logic                bus_rw_n_d;
  logic                bus_rw_noe_d;

  logic                scan_found;
  logic [IDX_W-1:0]    scan_pick;

  // Round-robin scan: start one past the last winner and walk upward with
  // wrap, so the most recently served channel is considered last. The
  // index is formed in a wide integer and folded back by subtraction,
  // which keeps non-power-of-two channel counts correct.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_n;
    scan_found = 1'b0;
    scan_pick  = '0;
    idx        = 0;
    idx_n      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_n = IDX_W'(idx);
      if (!scan_found && bus.req_valid_i[idx_n]) begin
        scan_found = 1'b1;
        scan_pick  = idx_n;
      end
    end
  end

  // Next-state and registered-output decode. Counter and phase advance
  // every clock regardless of the FSM; the FSM only reacts at the fixed
  // counter positions that bound a DMA bus cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    phase_d       = phase_q;
    last_d        = last_q;
    grant_d       = grant_q;
    xfer_addr_d   = xfer_addr_q;
    xfer_data_d   = xfer_data_q;
    xfer_rw_n_d   = xfer_rw_n_q;

    cpu_clk_d     = (phase_q == PH_CPU);
    cpu_be_d      = (phase_q == PH_CPU);
    ready_d       = '0;
    rd_data_d     = bus.rd_data_o;
    bus_addr_d    = bus.bus_addr_o;
    bus_addr_oe_d = 1'b0;
    bus_data_d    = bus.bus_data_o;
    bus_data_oe_d = 1'b0;
    bus_rw_n_d    = 1'b1;
    bus_rw_noe_d  = 1'b0;

    if (cnt_q == CNT_LAST) begin
      phase_d = (phase_q == PH_CPU) ? PH_DMA : PH_CPU;
    end

    case (state_q)
      IDLE: begin
        // Requests are looked at only on the first clock of the DMA half;
        // anything raised later waits for the next frame.
        if ((phase_q == PH_DMA) && (cnt_q == '0) && scan_found) begin
          state_d     = XFER;
          last_d      = scan_pick;
          grant_d     = scan_pick;
          xfer_addr_d = bus.req_addr_i[scan_pick*ADDR_W +: ADDR_W];
          xfer_data_d = bus.req_data_i[scan_pick*DATA_W +: DATA_W];
          xfer_rw_n_d = bus.req_rw_ni[scan_pick];
        end
      end

      XFER: begin
        bus_addr_oe_d = 1'b1;
        bus_addr_d    = xfer_addr_q;
        bus_rw_noe_d  = 1'b1;
        bus_rw_n_d    = xfer_rw_n_q;
        bus_data_d    = xfer_data_q;
        bus_data_oe_d = !xfer_rw_n_q;
        // Last driven clock: complete the cycle. Read data is only
        // captured for reads so a write leaves the last read visible.
        if (cnt_q == CNT_CAPT) begin
          state_d          = TURN;
          ready_d[grant_q] = 1'b1;
          if (xfer_rw_n_q) begin
            rd_data_d = bus.bus_data_i;
          end
        end
      end

      TURN: begin
        // One clock with every enable low before the CPU takes the bus.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears every enable at once, so a
  // transfer in flight is simply dropped without a ready pulse.
  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      phase_q         <= PH_CPU;
      cnt_q           <= '0;
      last_q          <= IDX_LAST;
      grant_q         <= '0;
      xfer_addr_q     <= '0;
      xfer_data_q     <= '0;
      xfer_rw_n_q     <= 1'b1;
      cpu_clk_o       <= 1'b0;
      cpu_be_o        <= 1'b0;
      bus.req_ready_o <= '0;
      bus.rd_data_o   <= '0;
      bus.bus_addr_o  <= '0;
      bus.bus_addr_oe <= 1'b0;
      bus.bus_data_o  <= '0;
      bus.bus_data_oe <= 1'b0;
      bus.bus_rw_no   <= 1'b1;
      bus.bus_rw_noe  <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      cnt_q           <= cnt_d;
      last_q          <= last_d;
      grant_q         <= grant_d;
      xfer_addr_q     <= xfer_addr_d;
      xfer_data_q     <= xfer_data_d;
      xfer_rw_n_q     <= xfer_rw_n_d;
      cpu_clk_o       <= cpu_clk_d;
      cpu_be_o        <= cpu_be_d;
      bus.req_ready_o <= ready_d;
      bus.rd_data_o   <= rd_data_d;
      bus.bus_addr_o  <= bus_addr_d;
      bus.bus_addr_oe <= bus_addr_oe_d;
      bus.bus_data_o  <= bus_data_d;
      bus.bus_data_oe <= bus_data_oe_d;
      bus.bus_rw_no   <= bus_rw_n_d;
      bus.bus_rw_noe  <= bus_rw_noe_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Drives bus_arbiter at its default parameters. Expected pin values come
// from a frame-position model: every rising edge after reset release is
// numbered, its position in the 2*PC-clock frame tells which half and which
// DMA slot is on the pins, and grants are chosen by plain round-robin
// arithmetic over the requests present at the first DMA slot.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int PC      = 8;
  localparam int FRAME   = 2 * PC;

  logic clk_sys_i = 1'b0;
  logic reset_i;
  logic cpu_clk_o;
  logic cpu_be_o;

  bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .PHASE_CYCLES(PC)
  ) dut (
    .clk_sys_i(clk_sys_i),
    .reset_i  (reset_i),
    .bus      (bus),
    .cpu_clk_o(cpu_clk_o),
    .cpu_be_o (cpu_be_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int                 edgeCount;
  int                 lastCh;
  bit                 act;
  int                 actCh;
  logic [ADDR_W-1:0]  actAddr;
  logic [DATA_W-1:0]  actData;
  logic               actRw;
  logic [DATA_W-1:0]  expRd;
  logic [NUM_REQ-1:0] expReady;

  // Requester behaviour and observed tallies
  bit autoDrop;
  int readyCount [NUM_REQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edgeCount);
    end
  endtask

  task automatic modelReset();
    edgeCount = 0;
    lastCh    = NUM_REQ - 1;
    act       = 1'b0;
    actCh     = 0;
    expRd     = '0;
    expReady  = '0;
  endtask

  task automatic clearCounts();
    for (int c = 0; c < NUM_REQ; c++) readyCount[c] = 0;
  endtask

  task automatic setReq(input int n, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic rw);
    bus.req_addr_i[n*ADDR_W +: ADDR_W] = a;
    bus.req_data_i[n*DATA_W +: DATA_W] = d;
    bus.req_rw_ni[n]                   = rw;
    bus.req_valid_i[n]                 = 1'b1;
  endtask

  // Advance the model by one rising edge; pos is the frame slot that the
  // pins show after this edge (0..PC-1 CPU half, PC..FRAME-1 DMA half).
  task automatic modelEdge();
    int pos;
    edgeCount++;
    pos      = (edgeCount - 1) % FRAME;
    expReady = '0;
    if (pos == PC && bus.req_valid_i != '0) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        int c;
        c = (lastCh + i) % NUM_REQ;
        if (bus.req_valid_i[c]) begin
          actCh = c;
          break;
        end
      end
      act     = 1'b1;
      lastCh  = actCh;
      actAddr = bus.req_addr_i[actCh*ADDR_W +: ADDR_W];
      actData = bus.req_data_i[actCh*DATA_W +: DATA_W];
      actRw   = bus.req_rw_ni[actCh];
    end
    if (act && pos == FRAME - 2) begin
      expReady[actCh] = 1'b1;
      if (actRw) expRd = bus.bus_data_i;
    end
  endtask

  task automatic checkOutput();
    int pos;
    bit cpu;
    bit xfer;
    pos  = (edgeCount - 1) % FRAME;
    cpu  = (pos < PC);
    xfer = act && (pos >= PC + 1) && (pos <= FRAME - 2);
    check("cpu_clk_o",   {31'd0, cpu_clk_o},       {31'd0, cpu});
    check("cpu_be_o",    {31'd0, cpu_be_o},        {31'd0, cpu});
    check("bus_addr_oe", {31'd0, bus.bus_addr_oe}, {31'd0, xfer});
    check("bus_rw_noe",  {31'd0, bus.bus_rw_noe},  {31'd0, xfer});
    check("bus_data_oe", {31'd0, bus.bus_data_oe}, {31'd0, xfer && !actRw});
    check("req_ready_o", 32'(bus.req_ready_o),     32'(expReady));
    check("rd_data_o",   32'(bus.rd_data_o),       32'(expRd));
    if (xfer) begin
      check("bus_addr_o", 32'(bus.bus_addr_o), 32'(actAddr));
      check("bus_rw_no",  {31'd0, bus.bus_rw_no}, {31'd0, actRw});
      if (!actRw) check("bus_data_o", 32'(bus.bus_data_o), 32'(actData));
    end
    if (pos == FRAME - 1) act = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    check({tag, ".cpu_clk_o"},   {31'd0, cpu_clk_o},       32'd0);
    check({tag, ".cpu_be_o"},    {31'd0, cpu_be_o},        32'd0);
    check({tag, ".bus_addr_oe"}, {31'd0, bus.bus_addr_oe}, 32'd0);
    check({tag, ".bus_data_oe"}, {31'd0, bus.bus_data_oe}, 32'd0);
    check({tag, ".bus_rw_noe"},  {31'd0, bus.bus_rw_noe},  32'd0);
    check({tag, ".req_ready_o"}, 32'(bus.req_ready_o),     32'd0);
    check({tag, ".rd_data_o"},   32'(bus.rd_data_o),       32'd0);
    check({tag, ".bus_addr_o"},  32'(bus.bus_addr_o),      32'd0);
    check({tag, ".bus_data_o"},  32'(bus.bus_data_o),      32'd0);
    check({tag, ".bus_rw_no"},   {31'd0, bus.bus_rw_no},   32'd1);
  endtask

  // Run n clocks, checking the pins after every edge. With autoDrop set a
  // requester lowers valid as soon as its ready pulse is expected.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk_sys_i);
      modelEdge();
      #1;
      checkOutput();
      for (int c = 0; c < NUM_REQ; c++) begin
        if (bus.req_ready_o[c]) readyCount[c]++;
        if (autoDrop && expReady[c]) bus.req_valid_i[c] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rData;
    logic              rRw;

    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.req_rw_ni   = '1;
    bus.bus_data_i  = '0;
    autoDrop        = 1'b1;
    clearCounts();
    modelReset();

    // Reset values
    reset_i = 1'b1;
    repeat (3) @(posedge clk_sys_i);
    #1;
    checkReset("reset");
    @(negedge clk_sys_i);
    reset_i = 1'b0;

    // Idle frames: CPU clock 8 high / 8 low, no enables
    applyStimulus(64);

    // Channel 0 read
    clearCounts();
    bus.bus_data_i = 8'hA5;
    setReq(0, 17'h08000, 8'h00, 1'b1);
    applyStimulus(FRAME);
    check("read.rd_data", 32'(bus.rd_data_o), 32'h0A5);
    check("read.ready0",  32'(readyCount[0]), 32'd1);

    // Channel 1 write, read data must be left alone
    clearCounts();
    bus.bus_data_i = 8'h77;
    setReq(1, 17'h1E800, 8'h3C, 1'b0);
    applyStimulus(FRAME);
    check("write.rd_data", 32'(bus.rd_data_o), 32'h0A5);
    check("write.ready1",  32'(readyCount[1]), 32'd1);

    // Both channels held valid for four frames
    clearCounts();
    autoDrop = 1'b0;
    bus.bus_data_i = 8'h19;
    setReq(0, 17'h00400, 8'h11, 1'b1);
    setReq(1, 17'h1F000, 8'h22, 1'b0);
    applyStimulus(4 * FRAME);
    check("rr.ready0", 32'(readyCount[0]), 32'd2);
    check("rr.ready1", 32'(readyCount[1]), 32'd2);
    bus.req_valid_i = '0;
    autoDrop = 1'b1;

    // Randomised requests
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < NUM_REQ; c++) begin
        if (!bus.req_valid_i[c] && $urandom_range(0, 1) == 1) begin
          rAddr = ADDR_W'($urandom);
          rData = DATA_W'($urandom);
          rRw   = 1'($urandom_range(0, 1));
          setReq(c, rAddr, rData, rRw);
        end
      end
      bus.bus_data_i = DATA_W'($urandom);
      applyStimulus(FRAME);
    end
    bus.req_valid_i = '0;

    // Request raised one clock after the grant point waits a whole frame
    clearCounts();
    applyStimulus(PC + 1);
    bus.bus_data_i = 8'h5A;
    setReq(0, 17'h0ABCD, 8'h00, 1'b1);
    applyStimulus(FRAME - PC - 1);
    check("late.same_frame", 32'(readyCount[0]), 32'd0);
    applyStimulus(FRAME);
    check("late.next_frame", 32'(readyCount[0]), 32'd1);
    check("late.rd_data",    32'(bus.rd_data_o), 32'h05A);

    // Reset in the middle of a write
    clearCounts();
    setReq(1, 17'h00123, 8'hC3, 1'b0);
    applyStimulus(PC + 4);
    #2;
    reset_i = 1'b1;
    #1;
    checkReset("midreset");
    @(posedge clk_sys_i);
    #1;
    checkReset("midreset_hold");
    check("midreset.ready1", 32'(readyCount[1]), 32'd0);
    @(negedge clk_sys_i);
    reset_i = 1'b0;
    modelReset();
    applyStimulus(2 * FRAME);
    check("restart.ready1", 32'(readyCount[1]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised system-bus sequencer that time-slices the shared PET bus between the 6502 and up to NUM_REQ host-side requesters (SPI bridge, future DMA/video fetch). It generates the CPU clock and bus-enable, and during each DMA phase grants one pending requester by round-robin, drives its address/data/rw onto the bus, and returns a ready pulse with captured read data. It replaces the fixed clock toggle and single-requester ready echo in the top level.

## Interface
- NUM_REQ, 2, number of requester channels (≥1)
- ADDR_W, 17, bus address width
- DATA_W, 8, bus data width
- PHASE_CYCLES, 8, clk_sys_i cycles per half-frame (≥4); CPU clock = clk_sys_i / (2·PHASE_CYCLES)

- clk_sys_i  input  1  system clock; one clock, all logic on rising edge
- reset_i  input  1  asynchronous, active-high reset
- req_valid_i  input  NUM_REQ  per-channel request pending
- req_addr_i  input  NUM_REQ·ADDR_W  packed addresses, channel n at [n·ADDR_W +: ADDR_W]
- req_data_i  input  NUM_REQ·DATA_W  packed write data
- req_rw_ni  input  NUM_REQ  1 = read, 0 = write
- req_ready_o  output  NUM_REQ  one-clock completion pulse, one-hot
- rd_data_o  output  DATA_W  read data, valid when any req_ready_o bit is high for a read
- bus_addr_o / bus_addr_oe  output  ADDR_W / 1  address and its enable
- bus_data_o / bus_data_oe  output  DATA_W / 1  write data and its enable
- bus_data_i  input  DATA_W  bus read data
- bus_rw_no / bus_rw_noe  output  1 / 1  rw strobe and its enable
- cpu_clk_o  output  1  CPU clock
- cpu_be_o  output  1  CPU bus enable

## Operation
- Phase counter cnt counts 0..PHASE_CYCLES-1 and wraps; phase bit toggles on wrap. CPU phase: cpu_clk_o=1, cpu_be_o=1, all bus enables 0. DMA phase: cpu_clk_o=0, cpu_be_o=0.
- FSM states: IDLE, XFER, TURN.
- IDLE, DMA phase, cnt=0: sample req_valid_i. Winner = first set bit scanning from (last+1) mod NUM_REQ upward with wrap. No bits set: stay IDLE for the whole phase. Otherwise latch the winner's addr/data/rw, set last=winner, go to XFER.
- XFER, cnt 1..PHASE_CYCLES-2: bus_addr_oe=1 and bus_rw_noe=1; bus_data_oe=1 only for writes. At cnt=PHASE_CYCLES-2, capture bus_data_i into rd_data_o (reads only) and pulse req_ready_o[winner], then go to TURN.
- TURN, cnt=PHASE_CYCLES-1: all enables 0. Return to IDLE.
- At most one transfer per frame. Requesters hold valid, addr, data and rw stable until ready. Valid still high in the next frame counts as a new request.
- Valid is sampled only at grant. Dropping it after grant violates the protocol; the cycle still completes and ready still pulses.
- rd_data_o holds its value until the next read capture. Writes leave it unchanged.
- NUM_REQ=1: scan collapses, and channel 0 wins whenever it is valid.

## Timing
- Reset values: cpu_clk_o=0, cpu_be_o=0, every *_oe=0, req_ready_o=0, rd_data_o=0, bus_addr_o=0, bus_data_o=0, bus_rw_no=1, cnt=0, phase=CPU, last=NUM_REQ-1 (channel 0 has first priority), FSM=IDLE.
- All outputs are registered. On the first rising edge after reset deasserts, cpu_clk_o and cpu_be_o go to 1 and the CPU phase begins.
- cpu_clk_o has a period of 2·PHASE_CYCLES clocks at a 50% duty cycle (default 16 MHz gives 1 MHz).
- Enables are 0 for at least 1 clock at both DMA-phase boundaries: cnt=0 (the grant cycle) and cnt=PHASE_CYCLES-1 (turnaround).
- Latency from grant to ready is PHASE_CYCLES-2 clocks. Worst-case wait is NUM_REQ frames.
- Reset asserted mid-XFER: enables drop immediately (asynchronous), no ready pulse, and the transfer is abandoned.
- cnt width is $clog2(PHASE_CYCLES).

## Test plan
- Reset then run 64 clocks at default parameters -> cpu_clk_o toggles every 8 clocks starting high, cpu_be_o follows it, and all enables stay 0 with no requests.
- ch0 read at 0x08000, bus_data_i=0xA5 -> bus_addr_oe high at DMA-phase cnt 1..6, req_ready_o=01 at cnt 6, rd_data_o=0xA5, bus_data_oe never 1.
- ch1 write of 0x3C to 0x1E800 -> bus_data_o=0x3C, bus_rw_no=0, bus_data_oe=1 during cnt 1..6, req_ready_o=10; rd_data_o unchanged.
- ch0 and ch1 both held valid for 4 frames -> grants alternate 0,1,0,1, and exactly one ready pulse per frame.
- Request raised at DMA-phase cnt=1 -> not granted until the next frame's DMA phase.
- reset_i pulsed at DMA-phase cnt=3 during a write -> enables are 0 that same cycle, no ready pulse, and the sequence restarts in the CPU phase.
